// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types, default widths and clog2 for the SDRAM port arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational winner search over the request vector from a start index
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int PORTS = 3,
    parameter int ID_W  = clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    int cand;

    // Walk the ports in circular order from start; first requester wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int k = 0; k < PORTS; k++) begin
            cand = (int'(start) + k) % PORTS;
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - single-outstanding SDRAM request port arbiter (SDRAM_ARB_ROUNDROBIN_EN selects round-robin, else fixed priority)
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int PORTS  = 3,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset_in,
    input  logic [PORTS-1:0]           port_req,
    input  logic [PORTS-1:0]           port_wr,
    input  logic [PORTS*ADDR_W-1:0]    port_addr,
    input  logic [PORTS*DATA_W-1:0]    port_wdata,
    input  logic [PORTS*2-1:0]         port_bsel,
    output logic [PORTS-1:0]           port_ack,
    output logic [DATA_W-1:0]          port_rdata,
    output logic                       ctrl_req,
    output logic                       ctrl_wr,
    output logic [ADDR_W-1:0]          ctrl_addr,
    output logic [DATA_W-1:0]          ctrl_wdata,
    output logic [1:0]                 ctrl_bsel,
    input  logic                       ctrl_ack,
    input  logic [DATA_W-1:0]          ctrl_rdata,
    output logic [clog2(PORTS)-1:0]    grant_id,
    output logic                       busy
);

    localparam int ID_W = clog2(PORTS);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [ID_W-1:0]  pick_start;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_valid;
    logic [PORTS-1:0] ack_vec;

    sdram_arb_pick #(
        .PORTS (PORTS),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (port_req),
        .start  (pick_start),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

`ifdef SDRAM_ARB_ROUNDROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    // Pointer holds the port after the last winner; it only moves on a grant.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            rr_ptr <= '0;
        end else if (state == ST_IDLE && pick_valid) begin
            rr_ptr <= (int'(pick_idx) == PORTS - 1) ? '0 : pick_idx + 1'b1;
        end
    end

    assign pick_start = rr_ptr;
`else
    assign pick_start = '0;
`endif

    assign ack_vec = PORTS'(1) << grant_id;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (pick_valid) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (ctrl_ack) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered so they line up with the state they belong to:
    // ctrl_req spans ISSUE..WAIT, port_ack covers exactly the DONE cycle.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            ctrl_req   <= 1'b0;
            ctrl_wr    <= 1'b0;
            ctrl_addr  <= '0;
            ctrl_wdata <= '0;
            ctrl_bsel  <= 2'b00;
            port_ack   <= '0;
            port_rdata <= '0;
            grant_id   <= '0;
        end else begin
            state    <= next_state;
            busy     <= (next_state != ST_IDLE);
            port_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id   <= pick_idx;
                        ctrl_req   <= 1'b1;
                        ctrl_wr    <= port_wr[pick_idx];
                        ctrl_addr  <= port_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        ctrl_wdata <= port_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        ctrl_bsel  <= port_bsel[int'(pick_idx)*2 +: 2];
                    end
                end
                ST_WAIT: begin
                    if (ctrl_ack) begin
                        ctrl_req   <= 1'b0;
                        port_rdata <= ctrl_rdata;
                        port_ack   <= ack_vec;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - transaction-timeline model bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int P  = 3;
    localparam int AW = 25;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset_in;
    logic [P-1:0]    port_req;
    logic [P-1:0]    port_wr;
    logic [P*AW-1:0] port_addr;
    logic [P*DW-1:0] port_wdata;
    logic [P*2-1:0]  port_bsel;
    logic [P-1:0]    port_ack;
    logic [DW-1:0]   port_rdata;
    logic            ctrl_req;
    logic            ctrl_wr;
    logic [AW-1:0]   ctrl_addr;
    logic [DW-1:0]   ctrl_wdata;
    logic [1:0]      ctrl_bsel;
    logic            ctrl_ack = 1'b0;
    logic [DW-1:0]   ctrl_rdata = '0;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.PORTS(P), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .port_req   (port_req),
        .port_wr    (port_wr),
        .port_addr  (port_addr),
        .port_wdata (port_wdata),
        .port_bsel  (port_bsel),
        .port_ack   (port_ack),
        .port_rdata (port_rdata),
        .ctrl_req   (ctrl_req),
        .ctrl_wr    (ctrl_wr),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_bsel  (ctrl_bsel),
        .ctrl_ack   (ctrl_ack),
        .ctrl_rdata (ctrl_rdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    typedef struct {
        int            grant;
        bit            chk;
        logic [DW-1:0] rd;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wd;
        logic [1:0]    bs;
    } lit_t;

    // Written by the stimulus process only
    lit_t          lits[32];
    int            lit_wr = 0;
    int            ctrl_wait = 0;
    logic [DW-1:0] rd_seed = '0;
    bit            stray_en = 1'b0;
    int            tmo_cnt = 0;
    bit            end_req = 1'b0;

    // Written by the monitor process only
    int            n_checks = 0;
    int            n_fail = 0;
    int            lit_rd = 0;
    int            ack_cnt[P] = '{0, 0, 0};
    bit            end_done = 1'b0;
    int            cyc = 0;
    bit            have_txn = 1'b0;
    int            t_g = 0, t_a = 0, t_next = 0;
    int            e_grant = 0;
    int            m_ptr = 0;
    logic          e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [1:0]    e_bsel = 2'b00;
    logic [DW-1:0] t_rdata = '0;
    logic [DW-1:0] m_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [P-1:0] req, input int start);
        for (int k = 0; k < P; k++) begin
            if (req[(start + k) % P]) return (start + k) % P;
        end
        return -1;
    endfunction

    // Transaction timeline: granted at negedge t_g, ctrl_req high t_g+1..t_a,
    // controller acks in cycle t_a, port_ack in t_a+1, next arbitration at t_a+2.
    always @(negedge clk) begin
        logic x_req, x_busy;
        logic [P-1:0] x_ack;
        int w, start;
        cyc = cyc + 1;
        if (!reset_in) begin
            have_txn = 1'b0; t_next = cyc; m_rdata = '0; e_grant = 0; m_ptr = 0;
            e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_bsel = 2'b00;
            check("rst_ctrl_req", ctrl_req, 0);
            check("rst_busy", busy, 0);
            check("rst_port_ack", port_ack, 0);
            check("rst_rdata", port_rdata, 0);
            check("rst_grant", grant_id, 0);
            check("rst_ctrl_cmd", {ctrl_wr, ctrl_bsel, ctrl_wdata}, 0);
            check("rst_ctrl_addr", ctrl_addr, 0);
            ctrl_ack = 1'b0;
        end else begin
            if (have_txn && cyc == t_a + 1) m_rdata = t_rdata;
            x_req  = have_txn && cyc > t_g && cyc <= t_a;
            x_busy = have_txn && cyc > t_g && cyc <= t_a + 1;
            x_ack  = (have_txn && cyc == t_a + 1) ? P'(1 << e_grant) : '0;
            check("ctrl_req", ctrl_req, x_req);
            check("busy", busy, x_busy);
            check("port_ack", port_ack, x_ack);
            check("port_rdata", port_rdata, m_rdata);
            check("grant_id", grant_id, e_grant);
            check("ctrl_wr", ctrl_wr, e_wr);
            check("ctrl_addr", ctrl_addr, e_addr);
            check("ctrl_wdata", ctrl_wdata, e_wdata);
            check("ctrl_bsel", ctrl_bsel, e_bsel);
            if (port_ack != '0) begin
                for (int i = 0; i < P; i++) if (port_ack[i]) ack_cnt[i]++;
                if (lit_rd < lit_wr) begin
                    check("lit_grant", grant_id, lits[lit_rd].grant);
                    if (lits[lit_rd].chk) begin
                        check("lit_rdata", port_rdata, lits[lit_rd].rd);
                        check("lit_addr", ctrl_addr, lits[lit_rd].addr);
                        check("lit_wr", ctrl_wr, lits[lit_rd].wr);
                        check("lit_wdata", ctrl_wdata, lits[lit_rd].wd);
                        check("lit_bsel", ctrl_bsel, lits[lit_rd].bs);
                    end
                    lit_rd++;
                end else begin
                    check("unlisted_ack", port_ack, 0);
                end
            end
            if (cyc >= t_next && port_req != '0) begin
`ifdef SDRAM_ARB_ROUNDROBIN_EN
                start = m_ptr;
`else
                start = 0;
`endif
                w = model_pick(port_req, start);
                m_ptr    = (w + 1) % P;
                have_txn = 1'b1;
                t_g      = cyc;
                t_a      = cyc + 2 + ctrl_wait;
                t_next   = t_a + 2;
                e_grant  = w;
                e_wr     = port_wr[w];
                e_addr   = port_addr[w*AW +: AW];
                e_wdata  = port_wdata[w*DW +: DW];
                e_bsel   = port_bsel[w*2 +: 2];
                t_rdata  = e_addr[DW-1:0] ^ rd_seed;
            end
            ctrl_ack   = have_txn && (cyc == t_a || (stray_en && (cyc == t_g + 1 || cyc == t_a + 1)));
            ctrl_rdata = (have_txn && cyc == t_a) ? t_rdata : 16'hDEAD;
        end
        if (end_req && !end_done) begin
            check("timeouts", tmo_cnt, 0);
            check("lits_left", lit_wr - lit_rd, 0);
            end_done = 1'b1;
        end
    end

    // Requester side: each port keeps req high while it has transactions left
    int       rem[P]  = '{0, 0, 0};
    int       seen[P] = '{0, 0, 0};
    logic [P-1:0] pulse = '0;
    int       trig_src = -1, trig_n = 0, trig_dst = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < P; i++) begin
            while (seen[i] < ack_cnt[i]) begin
                seen[i]++;
                if (rem[i] > 0) rem[i]--;
            end
        end
        if (trig_src >= 0 && seen[trig_src] >= trig_n) begin
            rem[trig_dst]++;
            trig_src = -1;
        end
        for (int i = 0; i < P; i++) port_req[i] = (rem[i] > 0) || pulse[i];
        pulse = '0;
    endtask

    task automatic quiet(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((n < 4 || rem[0] > 0 || rem[1] > 0 || rem[2] > 0 || busy) && n < budget);
        if (n >= budget) tmo_cnt++;
        tick();
    endtask

    task automatic set_port(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [1:0] b);
        port_wr[i]           = wr;
        port_addr[i*AW +: AW] = a;
        port_wdata[i*DW +: DW] = d;
        port_bsel[i*2 +: 2]  = b;
    endtask

    task automatic push_lit(input int g, input bit chk, input logic [DW-1:0] rd, input logic [AW-1:0] a,
                            input logic wr, input logic [DW-1:0] d, input logic [1:0] b);
        lits[lit_wr] = '{g, chk, rd, a, wr, d, b};
        lit_wr++;
    endtask

    task automatic do_reset();
        tick();
        reset_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b1;
    endtask

    initial begin
        reset_in   = 1'b0;
        port_req   = '0;
        port_wr    = '0;
        port_addr  = '0;
        port_wdata = '0;
        port_bsel  = '0;
        tick(); tick(); tick();
        reset_in = 1'b1;

        // Port 1 read with a 3-cycle controller wait
        ctrl_wait = 3;
        rd_seed   = 16'hACDB;
        set_port(1, 1'b0, 25'h0001234, 16'h1111, 2'b11);
        push_lit(1, 1'b1, 16'hBEEF, 25'h0001234, 1'b0, 16'h1111, 2'b11);
        rem[1] = 1;
        quiet(60);

        // All three ports request together straight out of reset
        do_reset();
        ctrl_wait = 0;
        rd_seed   = 16'h0000;
        set_port(0, 1'b0, 25'h0000100, 16'h0100, 2'b11);
        set_port(1, 1'b1, 25'h0000200, 16'h0200, 2'b10);
        set_port(2, 1'b0, 25'h0000300, 16'h0300, 2'b01);
        push_lit(0, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(1, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(2, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        rem = '{1, 1, 1};
        quiet(80);

        // Port 0 streams three transactions; port 2 joins at port 0's second ack
        do_reset();
        ctrl_wait = 1;
`ifdef SDRAM_ARB_ROUNDROBIN_EN
        push_lit(0, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(0, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(2, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(0, 1'b0, '0, '0, 1'b0, '0, 2'b00);
`else
        push_lit(0, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(0, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(0, 1'b0, '0, '0, 1'b0, '0, 2'b00);
        push_lit(2, 1'b0, '0, '0, 1'b0, '0, 2'b00);
`endif
        trig_src = 0;
        trig_n   = seen[0] + 2;
        trig_dst = 2;
        rem[0]   = 3;
        quiet(120);

        // Port 2 write; its inputs change mid-WAIT and stray acks hit ISSUE/DONE
        ctrl_wait = 3;
        stray_en  = 1'b1;
        set_port(2, 1'b1, 25'h1ABCDE, 16'hA5A5, 2'b01);
        push_lit(2, 1'b1, 16'hBCDE, 25'h1ABCDE, 1'b1, 16'hA5A5, 2'b01);
        rem[2] = 1;
        tick(); tick(); tick();
        set_port(2, 1'b0, 25'h0000000, 16'h5A5A, 2'b10);
        set_port(0, 1'b1, 25'h1FFFFFF, 16'hFFFF, 2'b11);
        quiet(60);
        stray_en = 1'b0;

        // Port 0 write with bsel 00, req dropped right after the grant
        ctrl_wait = 2;
        set_port(0, 1'b1, 25'h0000ABC, 16'h1234, 2'b00);
        push_lit(0, 1'b1, 16'h0ABC, 25'h0000ABC, 1'b1, 16'h1234, 2'b00);
        pulse[0] = 1'b1;
        quiet(60);

        // Reset during WAIT loses the transaction; the held request is then served
        ctrl_wait = 5;
        set_port(1, 1'b0, 25'h0155555, 16'h0000, 2'b11);
        push_lit(1, 1'b1, 16'h5555, 25'h0155555, 1'b0, 16'h0000, 2'b11);
        rem[1] = 1;
        tick(); tick(); tick();
        reset_in = 1'b0;
        tick();
        reset_in = 1'b1;
        quiet(60);

        tick(); tick();
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_done; i++) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
